// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/soft-stop sequencer for the PWM duty input: accepts a target duty
// and moves the live duty toward it in saturating steps on PWM period boundaries.
module pwm_ramp_sequencer #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [WIDTH-1:0]  target_i,
    input  logic              target_valid_i,
    output logic              target_ready_o,
    input  logic [WIDTH-1:0]  step_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              period_tick_i,
    input  logic              stop_i,
    output logic [WIDTH-1:0]  duty_o,
    output logic              duty_update_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   duty_q, duty_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [RATE_W-1:0]  count_q, count_d;
    logic               update_q, update_d;

    logic               busy;
    logic               accept;
    logic               stop;
    logic               step_event;
    logic [WIDTH:0]     step_eff;
    logic [WIDTH:0]     gap_up;
    logic [WIDTH:0]     gap_dn;
    logic [WIDTH-1:0]   duty_step;

    assign busy       = (state_q == UP) || (state_q == DOWN);
    assign stop       = ena && stop_i;
    assign accept     = target_valid_i && target_ready_o && !stop_i;
    assign step_event = period_tick_i && ena && busy && (count_q == rate_i);

    // Extra bit keeps the distance-to-target compare free of wrap-around.
    assign step_eff = (step_i == '0) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, step_i};
    assign gap_up   = {1'b0, target_q} - {1'b0, duty_q};
    assign gap_dn   = {1'b0, duty_q} - {1'b0, target_q};

    always_comb begin
        duty_step = duty_q;
        if (state_q == UP) begin
            duty_step = (gap_up <= step_eff) ? target_q : duty_q + step_eff[WIDTH-1:0];
        end else if (state_q == DOWN) begin
            duty_step = (gap_dn <= step_eff) ? target_q : duty_q - step_eff[WIDTH-1:0];
        end
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        count_d  = count_q;
        update_d = 1'b0;

        if (stop) begin
            target_d = '0;
            count_d  = '0;
            state_d  = (duty_q != '0) ? DOWN : IDLE;
        end else if (accept) begin
            target_d = target_i;
            count_d  = '0;
            if (target_i > duty_q) begin
                state_d = UP;
            end else if (target_i < duty_q) begin
                state_d = DOWN;
            end
        end else if (step_event) begin
            count_d  = '0;
            duty_d   = duty_step;
            update_d = 1'b1;
            if (duty_step == target_q) begin
                state_d = IDLE;
            end
        end else if (period_tick_i && ena && busy) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            count_q  <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            count_q  <= count_d;
            update_q <= update_d;
        end
    end

    assign target_ready_o = (state_q == IDLE) && ena;
    assign duty_o         = duty_q;
    assign duty_update_o  = update_q;
    assign busy_o         = busy;

endmodule
